// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, bubble masking and stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with registered in_ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, in_ready=1
//   ST_ONE   | head register M valid, in_ready=1
//   ST_TWO   | M and skid register S valid, in_ready=0
module pipe_stage_reg #(
    parameter int                 DATA_W   = 224,
    parameter int                 CTRL_W   = 21,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              accept;
    logic              retire;

`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_ready_r;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              load_m_in;
    logic              load_m_skid;
    logic              load_s;

    assign m_valid   = (state != ST_EMPTY);
    assign in_ready  = in_ready_r;
    assign accept    = in_valid && in_ready_r;
    assign retire    = m_valid && out_ready;
    assign occupancy = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !retire)
                    state_nxt = ST_TWO;
                else if (!accept && retire)
                    state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (retire) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush)
            state_nxt = ST_EMPTY;
    end

    // in_ready is a pure register so no combinational path runs back from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt != ST_TWO);
        end
    end

    assign load_m_in   = accept && ((state == ST_EMPTY) || ((state == ST_ONE) && retire));
    assign load_m_skid = (state == ST_TWO) && retire;
    assign load_s      = accept && (state == ST_ONE) && !retire;

    // payload registers need no reset: contents are masked whenever not valid
    always_ff @(posedge clk) begin
        if (load_m_in) begin
            m_data <= in_data;
            m_ctrl <= in_ctrl;
        end else if (load_m_skid) begin
            m_data <= s_data;
            m_ctrl <= s_ctrl;
        end
        if (load_s) begin
            s_data <= in_data;
            s_ctrl <= in_ctrl;
        end
    end
`else
    logic m_valid_r;

    assign m_valid   = m_valid_r;
    assign in_ready  = !m_valid_r || out_ready;
    assign accept    = in_valid && in_ready;
    assign retire    = m_valid_r && out_ready;
    assign occupancy = {1'b0, m_valid_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_valid_r <= 1'b0;
        else if (flush)
            m_valid_r <= 1'b0;
        else if (accept)
            m_valid_r <= 1'b1;
        else if (retire)
            m_valid_r <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            m_data <= in_data;
            m_ctrl <= in_ctrl;
        end
    end
`endif

    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data : {DATA_W{1'b0}};
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_NOP;

    // back-pressure is sampled independent of flush and never cleared by it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= {CNT_W{1'b0}};
        else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register; the next-generation replacement for the fixed-field per-stage latches between ID/EX, EX/MEM and MEM/WB. Carries an opaque data bus and a control bus with valid/ready flow control, a synchronous flush for branch/exception squash, and bubble masking so downstream write enables are never spuriously asserted. An optional 2-entry skid buffer registers the upstream ready, breaking the combinational ready chain across stages.

## Interface

- DATA_W, 224, width of data payload (pc, pc4, operands, immediates, inst)
- CTRL_W, 21, width of control payload (alu_op, wD_sel, wb_ena, ...)
- CTRL_NOP, {CTRL_W{1'b0}}, control value driven while out_valid=0
- CNT_W, 16, width of stall counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream data
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  head data; 0 when out_valid=0
- out_ctrl  out  CTRL_W  head control; CTRL_NOP when out_valid=0
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation

- Accept: in_valid && in_ready at a rising edge. Retire: out_valid && out_ready at a rising edge.
- Skid build: head register M, skid register S; states EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - EMPTY: accept -> M<=in, ONE.
  - ONE: accept+retire -> M<=in, ONE; accept only -> S<=in, TWO; retire only -> EMPTY; neither -> ONE.
  - TWO: in_ready=0, no accept; retire -> M<=S, ONE; else hold.
  - in_ready = registered, 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready.
- Non-skid build: M only; occupancy 0/1; in_ready = !M_valid || out_ready (combinational).
- Ordering strictly FIFO; no entry dropped or duplicated except by flush.
- Flush: next state EMPTY, all valids 0; an accept in the flush cycle is discarded; flush wins over accept and retire. Data contents of M/S are don't-care after flush (masked at output).
- Bubble masking: out_data=0, out_ctrl=CTRL_NOP whenever out_valid=0.
- stall_cnt: +1 for each cycle with out_valid && !out_ready (sampled before flush); saturates at 2^CNT_W-1; unaffected by flush; cleared only by reset.

## Timing

- Latency: accepted entry appears at out_valid in the cycle after acceptance (1 cycle).
- Throughput: 1 entry/cycle sustained when out_ready=1, both builds.
- Skid: after out_ready falls, stage absorbs one further upstream entry; in_ready falls the cycle after entering TWO... i.e. in_ready is low for the whole cycle the stage is in TWO, rises the cycle after the retire from TWO.
- Reset (rst_n=0, asynchronous): state EMPTY, out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occupancy=0, stall_cnt=0, in_ready=1 (non-skid: in_ready=1 combinationally since M_valid=0). Deassertion takes effect at next clk edge; reset mid-transfer discards all held entries.
- Flush takes effect on the edge where sampled; out_valid=0 the following cycle.

## Configuration

- PIPE_STAGE_SKID_EN defined: 2-entry skid build, registered in_ready, occupancy 0..2.
- Undefined: single-register build, combinational in_ready, occupancy bit 1 tied 0, S register absent.

## Test plan

- Reset: drive rst_n=0 mid-stream with occupancy=2 -> out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, stall_cnt=0, in_ready=1 immediately.
- Streaming: in_valid=1 every cycle, data 0..99, out_ready=1 -> out_data 0..99 in order, one per cycle, 1-cycle latency, stall_cnt=0.
- Back-pressure (skid): stream 0..9, hold out_ready=0 for 5 cycles -> occupancy reaches 2, in_ready=0, no loss/duplication, stall_cnt=5.
- Flush: occupancy=2 with entries A,B, assert flush with in_valid=1 carrying C -> next cycle out_valid=0, occupancy=0; A,B,C never appear at output.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15.
- Random: random in_valid/out_ready/flush over 10k cycles, both builds -> scoreboard matches FIFO order modulo flush; out_ctrl==CTRL_NOP whenever out_valid=0.
